// File: rtl/perf_pkg.sv
// Shared encodings for the performance counter bank: channel modes and freeze FSM states.
package perf_pkg;
  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_LEVEL = 2'b01;
  localparam logic [1:0] MODE_EDGE  = 2'b10;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_e;
endpackage

// File: rtl/perf_channel.sv
// One event counter: mode/sat config, edge history, sticky overflow and snapshot shadow.
module perf_channel
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en_i,
  input  logic             ev_i,
  input  logic             clr_i,
  input  logic             snap_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_mode_i,
  input  logic             cfg_sat_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] shadow_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, shadow_q;
  logic [1:0]       mode_q;
  logic             sat_q, ovf_q, ovf_d, prev_q, hit;

  always_comb begin
    hit = 1'b0;
    if (cnt_en_i) begin
      if (mode_q == MODE_LEVEL)     hit = ev_i;
      else if (mode_q == MODE_EDGE) hit = ev_i & ~prev_q;
    end
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (hit) begin
      if (cnt_q == {CNT_W{1'b1}}) begin
        ovf_d = 1'b1;
        if (!sat_q) cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
      prev_q   <= 1'b0;
      mode_q   <= MODE_LEVEL;
      sat_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      // history tracks the line even while frozen so resume sees no false edge
      prev_q <= ev_i;
      if (snap_i) shadow_q <= cnt_q;
      if (cfg_we_i) begin
        mode_q <= cfg_mode_i;
        sat_q  <= cfg_sat_i;
      end
    end
  end

  assign cnt_o    = cnt_q;
  assign shadow_o = shadow_q;
  assign ovf_o    = ovf_q;
endmodule

// File: rtl/perf_counter_bank.sv
// NUM_CH event counters with a halt-driven freeze FSM, atomic snapshot and registered readout.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              resume,
  input  logic [NUM_CH-1:0] event_in,
  input  logic [NUM_CH-1:0] clr_ch,
  input  logic              cfg_we,
  input  logic [SEL_W-1:0]  cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_sat,
  input  logic              snap_req,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_src,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              frozen
);
  state_e state_q;
  logic   frozen_q, cnt_en;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt, shadow;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      frozen_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: if (halt) begin
          state_q  <= ST_FROZEN;
          frozen_q <= 1'b1;
        end
        ST_FROZEN: if (resume && !halt) begin
          state_q  <= ST_RUN;
          frozen_q <= 1'b0;
        end
        default: begin
          state_q  <= ST_RUN;
          frozen_q <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_en = (state_q == ST_RUN) && !halt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .cnt_en_i  (cnt_en),
      .ev_i      (event_in[i]),
      .clr_i     (clr_ch[i]),
      .snap_i    (snap_req),
      .cfg_we_i  (cfg_we && (cfg_ch == SEL_W'(i))),
      .cfg_mode_i(cfg_mode),
      .cfg_sat_i (cfg_sat),
      .cnt_o     (cnt[i]),
      .shadow_o  (shadow[i]),
      .ovf_o     (ovf[i])
    );
  end

  // out-of-range selects match no channel and read as zero
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (rd_sel == SEL_W'(i)) rd_data_d = rd_src ? shadow[i] : cnt[i];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
  assign frozen  = frozen_q;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank (NUM_CH=4, CNT_W=8) with hand-computed expectations.
module tb_perf_counter_bank;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 4;

  logic              clk = 1'b0;
  logic              rst, halt, resume, cfg_we, cfg_sat, snap_req, rd_src;
  logic [NUM_CH-1:0] event_in, clr_ch, ovf;
  logic [SEL_W-1:0]  cfg_ch, rd_sel;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  rd_data;
  logic              frozen;
  int checks = 0;
  int errors = 0;

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .halt(halt), .resume(resume), .event_in(event_in),
    .clr_ch(clr_ch), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_sat(cfg_sat), .snap_req(snap_req), .rd_sel(rd_sel), .rd_src(rd_src),
    .rd_data(rd_data), .ovf(ovf), .frozen(frozen)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input int sel, input logic src, input int exp);
    rd_sel = SEL_W'(sel);
    rd_src = src;
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic cfg(input int ch, input logic [1:0] mode, input logic sat);
    cfg_we = 1'b1; cfg_ch = SEL_W'(ch); cfg_mode = mode; cfg_sat = sat;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b0; halt = 1'b0; resume = 1'b0; event_in = '0; clr_ch = '0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mode = 2'b00; cfg_sat = 1'b0;
    snap_req = 1'b0; rd_sel = '0; rd_src = 1'b0;

    do_rst();
    chk("rst_frozen", 32'(frozen), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_rd", 32'(rd_data), 0);

    event_in = 4'b0001;
    tick(5);
    event_in = '0;
    rd_chk("level_ch0", 0, 1'b0, 5);
    chk("level_ovf", 32'(ovf), 0);

    // edge vs level on the same pattern
    do_rst();
    cfg(1, 2'b10, 1'b0);
    pat = 8'b0111_0110;
    for (int i = 0; i < 8; i++) begin
      event_in = {2'b00, pat[i], pat[i]};
      tick();
    end
    event_in = '0;
    rd_chk("edge_ch1", 1, 1'b0, 2);
    rd_chk("level_ch0_pat", 0, 1'b0, 5);

    // wrap on ch2, saturate on ch3
    do_rst();
    cfg(3, 2'b01, 1'b1);
    event_in = 4'b1100;
    tick(257);
    event_in = '0;
    rd_chk("wrap_ch2", 2, 1'b0, 1);
    rd_chk("sat_ch3", 3, 1'b0, 255);
    chk("ovf_wrap_sat", 32'(ovf), 32'h0c);
    clr_ch = 4'b1000;
    tick();
    clr_ch = '0;
    rd_chk("clr_ch3", 3, 1'b0, 0);
    chk("clr_ovf3", 32'(ovf), 32'h04);

    // reset mid-count from a frozen, overflowed, nonzero-readout state
    rd_chk("pre_rst_ch2", 2, 1'b0, 1);
    halt = 1'b1;
    tick();
    chk("pre_rst_frozen", 32'(frozen), 1);
    event_in = 4'b1111; rst = 1'b1;
    tick();
    rst = 1'b0; halt = 1'b0; event_in = '0;
    chk("midrst_rd", 32'(rd_data), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    chk("midrst_frozen", 32'(frozen), 0);
    rd_chk("midrst_ch2", 2, 1'b0, 0);

    // freeze / resume
    do_rst();
    cfg(1, 2'b10, 1'b0);
    event_in = 4'b0011;
    tick(3);
    halt = 1'b1;
    tick(4);
    chk("halt_frozen", 32'(frozen), 1);
    rd_chk("halt_ch0", 0, 1'b0, 3);
    halt = 1'b0;
    tick();
    chk("halt_low_frozen", 32'(frozen), 1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_frozen", 32'(frozen), 0);
    tick(2);
    event_in = '0;
    rd_chk("resume_ch0", 0, 1'b0, 5);
    rd_chk("resume_ch1_edge", 1, 1'b0, 1);

    // snapshot + clear + event in the same cycle
    do_rst();
    event_in = 4'b0001;
    tick(10);
    snap_req = 1'b1; clr_ch = 4'b0001;
    tick();
    snap_req = 1'b0; clr_ch = '0; event_in = '0;
    rd_chk("snap_sh0", 0, 1'b1, 10);
    rd_chk("snap_live0", 0, 1'b0, 0);
    rd_chk("snap_sh1", 1, 1'b1, 0);

    // boundaries
    rd_chk("sel_oob", NUM_CH, 1'b1, 0);
    cfg(NUM_CH, 2'b00, 1'b1);
    event_in = 4'b1111;
    tick(3);
    event_in = '0;
    rd_chk("cfg_oob_ch0", 0, 1'b0, 3);
    rd_chk("cfg_oob_ch3", 3, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised successor to the fixed four-counter CPU statistics block (total / conditional / unconditional / taken-branch).
- Provides NUM_CH independent event counters of CNT_W bits.
- Per-channel mode (off / level / rising-edge) and wrap-or-saturate policy, with sticky overflow flags.
- Global freeze FSM driven by CPU halt; atomic snapshot of all channels; registered readout for the display/change_type path.

Parameters:
NUM_CH, 4, number of counter channels (1..16)
CNT_W, 32, counter width in bits (8..32)
SEL_W, 4, channel-select width; NUM_CH <= 2**SEL_W

Ports:
clk  in  1  system clock (CPU divided clock)
rst  in  1  synchronous reset, active-high
halt  in  1  CPU halt level; freezes counting
resume  in  1  pulse; leaves FROZEN when halt low
event_in  in  NUM_CH  per-channel event lines, bit i = channel i
clr_ch  in  NUM_CH  per-channel synchronous clear, bit i = channel i
cfg_we  in  1  write config for channel cfg_ch
cfg_ch  in  SEL_W  config target channel
cfg_mode  in  2  00 off, 01 level (count cycles high), 10 rising edge, 11 reserved = off
cfg_sat  in  1  1 saturate at max, 0 wrap
snap_req  in  1  pulse; copy all live counters to shadow
rd_sel  in  SEL_W  readout channel
rd_src  in  1  0 live counter, 1 shadow
rd_data  out  CNT_W  registered readout
ovf  out  NUM_CH  sticky overflow flags
frozen  out  1  FSM in FROZEN

Behaviour:
- Reset (rst=1 at clk edge):
  - all counters, shadows, ovf, rd_data, edge-history registers = 0.
  - FSM = RUN; frozen = 0.
  - every channel mode = 01 (level), sat = 0.
- FSM:
  - RUN -> FROZEN when halt=1.
  - FROZEN -> RUN when resume=1 and halt=0.
  - halt=1 together with resume=1 stays/enters FROZEN.
  - frozen = (state == FROZEN), registered.
- Count enable:
  - A channel increments only in RUN and when halt=0 in the same cycle (the halt cycle itself is not counted).
  - level mode: +1 on each cycle event_in[i]=1.
  - edge mode: +1 when event_in[i]=1 and previous-cycle event_in[i]=0.
  - Edge history updates every cycle, including in FROZEN, so no spurious edge is counted on resume.
- Overflow:
  - Applies to an increment at value 2**CNT_W-1.
  - wrap: value becomes 0 and ovf[i] is set.
  - sat: value holds at max and ovf[i] is set.
  - ovf[i] is sticky; cleared only by rst or clr_ch[i].
- clr_ch[i]: counter and ovf[i] = 0 next cycle. Clear wins over a same-cycle increment; that event is lost. Works in FROZEN.
- cfg_we: mode/sat for cfg_ch take effect the following cycle. cfg_ch >= NUM_CH is ignored. The counter value is not altered.
- snap_req: shadow[i] <= live value *before* the same-cycle increment/clear, for all i simultaneously. Works in any state.
- Readout:
  - rd_data registered, 1-cycle latency from rd_sel/rd_src.
  - rd_sel >= NUM_CH returns 0.
  - A same-cycle update is visible on the next read, not the current one.
- Priority per channel: rst > clr_ch > increment.
- No combinational path from inputs to outputs.

Decomposition:
- Package perf_pkg: mode encodings (MODE_OFF, MODE_LEVEL, MODE_EDGE) and FSM state constants (ST_RUN, ST_FROZEN).
- Sub-module perf_channel: one counter with edge detect, mode/sat config, overflow and shadow register.
- The top generates NUM_CH instances plus the FSM and readout mux.

Test Plan:
- Reset/level: rst, then event_in[0]=1 for 5 cycles, rd_sel=0 -> rd_data=5 one cycle after select; all ovf=0, frozen=0.
- Edge mode: cfg ch1 mode=10; event_in[1] pattern 0,1,1,0,1,1,1,0 -> ch1=2. Same pattern on level-mode ch0 -> ch0=5.
- Wrap vs saturate (CNT_W=8):
  - ch2 wrap, 257 level cycles -> ch2=1, ovf[2]=1.
  - ch3 sat, same stimulus -> ch3=255, ovf[3]=1.
  - clr_ch[3] -> ch3=0, ovf[3]=0.
- Freeze:
  - 3 events, then halt=1 for 4 cycles with event high -> count stays 3, frozen=1.
  - halt=0 alone -> still frozen.
  - resume pulse -> frozen=0, counting restarts next cycle; an edge-mode channel held high throughout does not increment.
- Snapshot and clear collision:
  - ch0=10; snap_req with event high and clr_ch[0] in the same cycle -> shadow0=10 (rd_src=1), live ch0=0 (rd_src=0).
- Boundaries:
  - rd_sel=NUM_CH -> rd_data=0.
  - cfg_we with cfg_ch=NUM_CH -> no channel config changes.
  - rst asserted mid-count -> all outputs 0 the next cycle.
